// File: rtl/axi_slave_package.sv
// Shared types and widths for the slave-bridge request recorder controller.
package axi_slave_package;

  localparam int REQUESTER_RECORDER_ADDR_WIDTH = 5;
  localparam int REQUESTER_RECORDER_WIDTH      = 48;

  typedef enum logic [1:0] {
    INIT_CLR,
    RUN,
    DRAIN
  } tag_ctrl_state_e;

  typedef enum logic {
    REQ_WR,
    REQ_RD
  } requester_e;

endpackage

// File: rtl/request_recorder_tag_ctrl_if.sv
// Tag allocation/release handshake between the AW/AR/P2A paths and the recorder tag controller.
interface request_recorder_tag_ctrl_if
  import axi_slave_package::*;
#(
  parameter int ADDR_W = REQUESTER_RECORDER_ADDR_WIDTH,
  parameter int DATA_W = REQUESTER_RECORDER_WIDTH
);

  logic              wr_alloc_req;
  logic [DATA_W-1:0] wr_alloc_data;
  logic              wr_alloc_gnt;
  logic              rd_alloc_req;
  logic [DATA_W-1:0] rd_alloc_data;
  logic              rd_alloc_gnt;
  logic [ADDR_W-1:0] alloc_tag;
  logic              release_valid;
  logic [ADDR_W-1:0] release_tag;

  modport master (
    output wr_alloc_req, wr_alloc_data, rd_alloc_req, rd_alloc_data,
    output release_valid, release_tag,
    input  wr_alloc_gnt, rd_alloc_gnt, alloc_tag
  );

  modport slave (
    input  wr_alloc_req, wr_alloc_data, rd_alloc_req, rd_alloc_data,
    input  release_valid, release_tag,
    output wr_alloc_gnt, rd_alloc_gnt, alloc_tag
  );

endinterface

// File: rtl/tag_free_list.sv
// Free bitmap of recorder tags (1 = free) with a lowest-index-first picker.
module tag_free_list #(
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   alloc_i,
  input  logic [ADDR_W-1:0]      allocTag_i,
  input  logic                   release_i,
  input  logic [ADDR_W-1:0]      releaseTag_i,
  output logic [(1<<ADDR_W)-1:0] freeMap_o,
  output logic                   anyFree_o,
  output logic [ADDR_W-1:0]      lowestFree_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] freeMap_q, freeMap_d;

  always_comb begin
    freeMap_d = freeMap_q;
    if (alloc_i)   freeMap_d[allocTag_i]   = 1'b0;
    if (release_i) freeMap_d[releaseTag_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) freeMap_q <= '1;
    else       freeMap_q <= freeMap_d;
  end

  // Scan from the top so the last hit is the lowest free index.
  always_comb begin
    lowestFree_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (freeMap_q[i]) lowestFree_o = ADDR_W'(i);
    end
  end

  assign anyFree_o = |freeMap_q;
  assign freeMap_o = freeMap_q;

endmodule

// File: rtl/request_recorder_tag_ctrl.sv
// Request Recorder tag controller: clears the RAM, arbitrates AW/AR tag allocation, frees tags.
// Optional watchdog on stalled outstanding tags: define REQ_RECORDER_WDOG_EN.
module request_recorder_tag_ctrl
  import axi_slave_package::*;
#(
  parameter int ADDR_W      = REQUESTER_RECORDER_ADDR_WIDTH,
  parameter int DATA_W      = REQUESTER_RECORDER_WIDTH,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                arst,
  request_recorder_tag_ctrl_if.slave alloc_if,
  input  logic                flush_req,
  output logic                ready,
  output logic [ADDR_W:0]     outstanding,
  output logic                release_err,
`ifdef REQ_RECORDER_WDOG_EN
  output logic                wdog_err,
`endif
  output logic                req_wr_en,
  output logic [ADDR_W-1:0]   req_wr_addr,
  output logic [DATA_W-1:0]   req_wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  tag_ctrl_state_e  state_q;
  requester_e       lastWinner_q;
  logic [ADDR_W-1:0] clrPtr_q;
  logic [ADDR_W:0]   outstanding_q;
  logic              releaseErr_q;
  logic              ready_q;

  logic [DEPTH-1:0]  freeMap;
  logic              anyFree;
  logic [ADDR_W-1:0] lowestFree;
  logic              grantWr, grantRd, grantAny;
  logic              relActive, relAccept;

  tag_free_list #(.ADDR_W(ADDR_W)) u_free_list (
    .clk          (clk),
    .arst         (arst),
    .alloc_i      (grantAny),
    .allocTag_i   (lowestFree),
    .release_i    (relAccept),
    .releaseTag_i (alloc_if.release_tag),
    .freeMap_o    (freeMap),
    .anyFree_o    (anyFree),
    .lowestFree_o (lowestFree)
  );

  // The flush cycle itself already blocks grants; on a tie the previous loser wins.
  always_comb begin
    grantWr = 1'b0;
    grantRd = 1'b0;
    if (state_q == RUN && anyFree && !flush_req) begin
      if (alloc_if.wr_alloc_req && alloc_if.rd_alloc_req) begin
        if (lastWinner_q == REQ_RD) grantWr = 1'b1;
        else                        grantRd = 1'b1;
      end else begin
        grantWr = alloc_if.wr_alloc_req;
        grantRd = alloc_if.rd_alloc_req;
      end
    end
  end

  assign grantAny  = grantWr | grantRd;
  assign relActive = alloc_if.release_valid && (state_q != INIT_CLR);
  assign relAccept = relActive && !freeMap[alloc_if.release_tag];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q       <= INIT_CLR;
      clrPtr_q      <= '0;
      lastWinner_q  <= REQ_RD;
      outstanding_q <= '0;
      releaseErr_q  <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        INIT_CLR: begin
          clrPtr_q <= clrPtr_q + 1'b1;
          if (clrPtr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (flush_req) begin
            state_q <= DRAIN;
            ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (outstanding_q == '0) begin
            state_q  <= INIT_CLR;
            clrPtr_q <= '0;
          end
        end
        default: state_q <= INIT_CLR;
      endcase

      if (grantAny) lastWinner_q <= grantWr ? REQ_WR : REQ_RD;

      case ({grantAny, relAccept})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase

      if (relActive && !relAccept) releaseErr_q <= 1'b1;
    end
  end

`ifdef REQ_RECORDER_WDOG_EN
  logic [31:0] wdogCnt_q, wdogCnt_d;
  logic        wdogErr_q;

  // Counts cycles without any release while tags are held; saturates at the limit.
  always_comb begin
    wdogCnt_d = wdogCnt_q;
    if (alloc_if.release_valid || outstanding_q == '0)
      wdogCnt_d = '0;
    else if (state_q != INIT_CLR && wdogCnt_q < 32'(WDOG_CYCLES))
      wdogCnt_d = wdogCnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wdogCnt_q <= '0;
      wdogErr_q <= 1'b0;
    end else begin
      wdogCnt_q <= wdogCnt_d;
      if (wdogCnt_d >= 32'(WDOG_CYCLES)) wdogErr_q <= 1'b1;
    end
  end

  assign wdog_err = wdogErr_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  assign alloc_if.wr_alloc_gnt = grantWr;
  assign alloc_if.rd_alloc_gnt = grantRd;
  assign alloc_if.alloc_tag    = grantAny ? lowestFree : '0;

  // Reset resolves to INIT_CLR; gating keeps the RAM untouched while reset is still held.
  assign req_wr_en   = arst && ((state_q == INIT_CLR) || grantAny);
  assign req_wr_addr = (state_q == INIT_CLR) ? clrPtr_q : (grantAny ? lowestFree : '0);
  assign req_wr_data = grantWr ? alloc_if.wr_alloc_data :
                       grantRd ? alloc_if.rd_alloc_data : '0;

  assign ready       = ready_q;
  assign outstanding = outstanding_q;
  assign release_err = releaseErr_q;

endmodule

// File: tb/tb_request_recorder_tag_ctrl.sv
// Randomized + directed bench for request_recorder_tag_ctrl against a set-of-used-tags model.
// Watchdog checks are active when REQ_RECORDER_WDOG_EN is defined.
module tb_request_recorder_tag_ctrl;
  import axi_slave_package::*;

  localparam int AW    = REQUESTER_RECORDER_ADDR_WIDTH;
  localparam int DW    = REQUESTER_RECORDER_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int WDOG  = 16;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          flush_req = 1'b0;
  logic          ready;
  logic [AW:0]   outstanding;
  logic          release_err;
  logic          req_wr_en;
  logic [AW-1:0] req_wr_addr;
  logic [DW-1:0] req_wr_data;
`ifdef REQ_RECORDER_WDOG_EN
  logic          wdog_err;
`endif

  request_recorder_tag_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) allocIf ();

  request_recorder_tag_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WDOG_CYCLES(WDOG)) dut (
    .clk         (clk),
    .arst        (arst),
    .alloc_if    (allocIf),
    .flush_req   (flush_req),
    .ready       (ready),
    .outstanding (outstanding),
    .release_err (release_err),
`ifdef REQ_RECORDER_WDOG_EN
    .wdog_err    (wdog_err),
`endif
    .req_wr_en   (req_wr_en),
    .req_wr_addr (req_wr_addr),
    .req_wr_data (req_wr_data)
  );

  always #5 clk = ~clk;

  bit used [DEPTH];
  int count, clearIdx;
  bit lastRd, relErr, clearing, draining;
  bit lastWrG, lastRdG;
`ifdef REQ_RECORDER_WDOG_EN
  int wdCnt;
  bit wdErr;
`endif
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    foreach (used[i]) used[i] = 1'b0;
    count = 0; clearIdx = 0; lastRd = 1'b1; relErr = 1'b0;
    clearing = 1'b1; draining = 1'b0; lastWrG = 1'b0; lastRdG = 1'b0;
`ifdef REQ_RECORDER_WDOG_EN
    wdCnt = 0; wdErr = 1'b0;
`endif
  endtask

  function automatic int pickUsed();
    int start;
    start = int'($urandom_range(0, DEPTH - 1));
    for (int k = 0; k < DEPTH; k++)
      if (used[(start + k) % DEPTH]) return (start + k) % DEPTH;
    return 0;
  endfunction

  // Called right after a falling edge: drive, check the model's view, advance it, wait a cycle.
  task automatic applyStimulus(input bit wr, input logic [DW-1:0] wd, input bit rd,
                               input logic [DW-1:0] rdd, input bit rv, input int rt, input bit fl);
    int lowest, countPre;
    bit expReady, gW, gR, relOk, relBad, wasClearing;
    allocIf.wr_alloc_req  = wr;
    allocIf.wr_alloc_data = wd;
    allocIf.rd_alloc_req  = rd;
    allocIf.rd_alloc_data = rdd;
    allocIf.release_valid = rv;
    allocIf.release_tag   = AW'(rt);
    flush_req             = fl;
    #1;
    expReady = !clearing && !draining;
    lowest = -1;
    for (int i = 0; i < DEPTH; i++) if (!used[i] && lowest < 0) lowest = i;
    gW = 1'b0; gR = 1'b0;
    if (expReady && !fl && lowest >= 0) begin
      if (wr && rd) begin gW = lastRd; gR = !lastRd; end
      else begin gW = wr; gR = rd; end
    end
    checkOutput("ready", 64'(ready), 64'(expReady));
    checkOutput("wr_gnt", 64'(allocIf.wr_alloc_gnt), 64'(gW));
    checkOutput("rd_gnt", 64'(allocIf.rd_alloc_gnt), 64'(gR));
    checkOutput("wr_en", 64'(req_wr_en), 64'(clearing || gW || gR));
    if (clearing) begin
      checkOutput("clr_addr", 64'(req_wr_addr), 64'(clearIdx));
      checkOutput("clr_data", 64'(req_wr_data), 64'(0));
    end else if (gW || gR) begin
      checkOutput("alloc_tag", 64'(allocIf.alloc_tag), 64'(lowest));
      checkOutput("wr_addr", 64'(req_wr_addr), 64'(lowest));
      checkOutput("wr_data", 64'(req_wr_data), 64'(gW ? wd : rdd));
    end
    checkOutput("outstanding", 64'(outstanding), 64'(count));
    checkOutput("release_err", 64'(release_err), 64'(relErr));
`ifdef REQ_RECORDER_WDOG_EN
    checkOutput("wdog_err", 64'(wdog_err), 64'(wdErr));
`endif
    countPre    = count;
    wasClearing = clearing;
    relOk  = !clearing && rv && used[rt];
    relBad = !clearing && rv && !used[rt];
    if (clearing) begin
      clearIdx++;
      if (clearIdx == DEPTH) clearing = 1'b0;
    end else if (draining) begin
      if (countPre == 0) begin draining = 1'b0; clearing = 1'b1; clearIdx = 0; end
    end else if (fl) begin
      draining = 1'b1;
    end
    if (gW || gR) begin used[lowest] = 1'b1; count++; lastRd = gR; end
    if (relOk) begin used[rt] = 1'b0; count--; end
    if (relBad) relErr = 1'b1;
`ifdef REQ_RECORDER_WDOG_EN
    if (rv || countPre == 0) wdCnt = 0;
    else if (!wasClearing) wdCnt++;
    if (wdCnt >= WDOG) wdErr = 1'b1;
`endif
    lastWrG = gW;
    lastRdG = gR;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic doReset();
    arst = 1'b0;
    allocIf.wr_alloc_req = 1'b0; allocIf.rd_alloc_req = 1'b0;
    allocIf.wr_alloc_data = '0;  allocIf.rd_alloc_data = '0;
    allocIf.release_valid = 1'b0; allocIf.release_tag = '0;
    flush_req = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_ready", 64'(ready), 64'(0));
    checkOutput("rst_wr_en", 64'(req_wr_en), 64'(0));
    checkOutput("rst_wr_addr", 64'(req_wr_addr), 64'(0));
    checkOutput("rst_wr_data", 64'(req_wr_data), 64'(0));
    checkOutput("rst_outstanding", 64'(outstanding), 64'(0));
    checkOutput("rst_release_err", 64'(release_err), 64'(0));
    checkOutput("rst_gnt", 64'({allocIf.wr_alloc_gnt, allocIf.rd_alloc_gnt}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_wr_en_held", 64'(req_wr_en), 64'(0));
    arst = 1'b1;
  endtask

  logic [DW-1:0] wd, rdd;
  bit wrReq, rdReq, rv, fl;
  int rt;

  initial begin
    $display("[TB] start");
    allocIf.wr_alloc_req = 1'b0; allocIf.rd_alloc_req = 1'b0;
    allocIf.release_valid = 1'b0; allocIf.release_tag = '0;
    allocIf.wr_alloc_data = '0; allocIf.rd_alloc_data = '0;
    @(negedge clk);
    doReset();
    idle(DEPTH + 1);

    // Both requesters held: alternate WR, RD, WR, RD on tags 0..3
    wd  = DW'(64'h0000_AAAA_0000_0001);
    rdd = DW'(64'h0000_BBBB_0000_0001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, wd, 1'b1, rdd, 1'b0, 0, 1'b0);
      if (lastWrG) wd  = wd + 1'b1;
      if (lastRdG) rdd = rdd + 1'b1;
    end
    checkOutput("four_grants_cnt", 64'(outstanding), 64'(4));
    for (int t = 0; t < 4; t++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, t, 1'b0);

    // Fill every tag, then a refused request, then tag 7 freed and regranted one cycle later
    for (int k = 0; k < DEPTH + 1; k++) begin
      applyStimulus(1'b1, wd, 1'b0, '0, 1'b0, 0, 1'b0);
      if (lastWrG) wd = wd + 1'b1;
    end
    checkOutput("full_cnt", 64'(outstanding), 64'(DEPTH));
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b0, 0, 1'b0);
    checkOutput("regrant_cnt", 64'(outstanding), 64'(DEPTH));
    wd = wd + 1'b1;
    for (int t = 0; t < DEPTH; t++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, t, 1'b0);

    // Release tag 0 while allocating: tag 1 granted, count steady, then tag 0 again
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b0, 0, 1'b0); wd = wd + 1'b1;
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b1, 0, 1'b0); wd = wd + 1'b1;
    checkOutput("same_cycle_cnt", 64'(outstanding), 64'(1));
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b0, 0, 1'b0); wd = wd + 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1, 1'b0);

    // Releasing an already-free tag
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 5, 1'b0);
    idle(2);
    checkOutput("err_sticky", 64'(release_err), 64'(1));
    checkOutput("err_cnt", 64'(outstanding), 64'(0));

    // Flush with three tags outstanding
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, '0, 1'b1, rdd, 1'b0, 0, 1'b0);
      rdd = rdd + 1'b1;
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, wd, 1'b1, rdd, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, wd, 1'b1, rdd, 1'b0, 0, 1'b0);
    for (int t = 0; t < 3; t++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, t, 1'b0);
    idle(DEPTH + 2);
    checkOutput("ready_after_flush", 64'(ready), 64'(1));

    // Random traffic; requests hold with stable data until granted
    wrReq = 1'b0; rdReq = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!(wrReq && !lastWrG)) begin
        wrReq = ($urandom_range(0, 2) == 0);
        wd    = DW'({$urandom(), $urandom()});
      end
      if (!(rdReq && !lastRdG)) begin
        rdReq = ($urandom_range(0, 2) == 0);
        rdd   = DW'({$urandom(), $urandom()});
      end
      rv = 1'b0; rt = 0;
      if (count > 0 && $urandom_range(0, 3) == 0) begin
        rv = 1'b1; rt = pickUsed();
      end else if ($urandom_range(0, 29) == 0) begin
        rv = 1'b1; rt = int'($urandom_range(0, DEPTH - 1));
      end
      fl = ($urandom_range(0, 149) == 0);
      applyStimulus(wrReq, wd, rdReq, rdd, rv, rt, fl);
    end

    // Reset mid-operation, then again mid-clear: clear must restart at address 0
    doReset();
    idle(10);
    doReset();
    idle(DEPTH + 1);

`ifdef REQ_RECORDER_WDOG_EN
    applyStimulus(1'b1, wd, 1'b0, '0, 1'b0, 0, 1'b0);
    idle(WDOG - 1);
    checkOutput("wdog_early", 64'(wdog_err), 64'(0));
    idle(1);
    checkOutput("wdog_fire", 64'(wdog_err), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
